inverse_permutation: RTL and testbench

Registered DES inverse P-box (P⁻¹) with a valid/ready handshake on both sides and a 2-entry output FIFO. It undoes the 32-bit P permutation of the DES round function, for the decryption datapath and for self-test of the forward P stage. It sits between the round-function output register and downstream consumers that may stall.

---
 rtl/inverse_permutation.sv | 141 ++++++++++++++
 tb/tb_inverse_permutation.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/inverse_permutation.sv
// DES inverse P-box (P^-1) feeding a 2-entry valid/ready output FIFO, with a popped-word counter.
// Optional macro INV_PERM_ROUNDTRIP_CHECK_EN adds raw-word storage and a forward-P round-trip checker.
module inverse_permutation (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [32:1] Inv_Perm_Input,
    input  logic        Inv_Perm_In_Valid,
    output logic        Inv_Perm_In_Ready,
    output logic [32:1] Inv_Perm_Output,
    output logic        Inv_Perm_Out_Valid,
    input  logic        Inv_Perm_Out_Ready,
    output logic [7:0]  Inv_Perm_Count,
    output logic        Inv_Perm_Check_Error
);

    // state | meaning
    // EMPTY | no word buffered, accepting input
    // ONE   | head valid, one slot free
    // FULL  | both slots used, input stalled
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    function automatic logic [32:1] inv_p(input logic [32:1] d);
        inv_p = {d[24], d[16], d[10], d[2],  d[20], d[5],  d[31], d[15],
                 d[9],  d[17], d[3],  d[27], d[7],  d[13], d[23], d[32],
                 d[25], d[19], d[8],  d[30], d[29], d[4],  d[22], d[14],
                 d[1],  d[21], d[11], d[26], d[28], d[6],  d[18], d[12]};
    endfunction

    occ_t        occ_q;
    occ_t        occ_d;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [32:1] mem [2];
    logic [7:0]  count;
    logic        push;
    logic        pop;

    always_comb begin
        Inv_Perm_In_Ready  = 1'b1;
        Inv_Perm_Out_Valid = 1'b0;
        case (occ_q)
            EMPTY: begin
                Inv_Perm_In_Ready  = 1'b1;
                Inv_Perm_Out_Valid = 1'b0;
            end
            ONE: begin
                Inv_Perm_In_Ready  = 1'b1;
                Inv_Perm_Out_Valid = 1'b1;
            end
            FULL: begin
                Inv_Perm_In_Ready  = 1'b0;
                Inv_Perm_Out_Valid = 1'b1;
            end
            default: begin
                Inv_Perm_In_Ready  = 1'b1;
                Inv_Perm_Out_Valid = 1'b0;
            end
        endcase
    end

    assign push = Inv_Perm_In_Valid & Inv_Perm_In_Ready;
    assign pop  = Inv_Perm_Out_Valid & Inv_Perm_Out_Ready;

    always_comb begin
        occ_d = occ_q;
        case (occ_q)
            EMPTY: if (push) occ_d = ONE;
            ONE: begin
                if (push && !pop)      occ_d = FULL;
                else if (!push && pop) occ_d = EMPTY;
            end
            FULL: if (pop) occ_d = ONE;
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= 32'h0;
            mem[1] <= 32'h0;
            count  <= 8'h00;
        end else begin
            occ_q <= occ_d;
            if (push) begin
                mem[wr_ptr] <= inv_p(Inv_Perm_Input);
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                count  <= count + 8'd1;
            end
        end
    end

    assign Inv_Perm_Output = mem[rd_ptr];
    assign Inv_Perm_Count  = count;

`ifdef INV_PERM_ROUNDTRIP_CHECK_EN
    function automatic logic [32:1] fwd_p(input logic [32:1] d);
        logic [32:1] r;
        r[24] = d[32]; r[16] = d[31]; r[10] = d[30]; r[2]  = d[29];
        r[20] = d[28]; r[5]  = d[27]; r[31] = d[26]; r[15] = d[25];
        r[9]  = d[24]; r[17] = d[23]; r[3]  = d[22]; r[27] = d[21];
        r[7]  = d[20]; r[13] = d[19]; r[23] = d[18]; r[32] = d[17];
        r[25] = d[16]; r[19] = d[15]; r[8]  = d[14]; r[30] = d[13];
        r[29] = d[12]; r[4]  = d[11]; r[22] = d[10]; r[14] = d[9];
        r[1]  = d[8];  r[21] = d[7];  r[11] = d[6];  r[26] = d[5];
        r[28] = d[4];  r[6]  = d[3];  r[18] = d[2];  r[12] = d[1];
        return r;
    endfunction

    logic [32:1] raw [2];
    logic        check_err;

    // Raw word travels alongside its permuted copy so the pop can verify the round trip
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw[0]    <= 32'h0;
            raw[1]    <= 32'h0;
            check_err <= 1'b0;
        end else begin
            if (push)
                raw[wr_ptr] <= Inv_Perm_Input;
            if (pop && (fwd_p(mem[rd_ptr]) != raw[rd_ptr]))
                check_err <= 1'b1;
        end
    end

    assign Inv_Perm_Check_Error = check_err;
`else
    assign Inv_Perm_Check_Error = 1'b0;
`endif

endmodule

// File: tb/tb_inverse_permutation.sv
// Directed-vector bench for inverse_permutation: single bits, patterns, walking one,
// backpressure, concurrent push/pop and asynchronous reset with the FIFO full.
module tb_inverse_permutation;

    logic        clk;
    logic        rst_n;
    logic [32:1] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [32:1] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  count;
    logic        check_err;

    int n_tests;
    int n_fail;
    int exp_count;

    // Output bit i takes input bit src[i]
    int src [32:1] = '{24, 16, 10, 2, 20, 5, 31, 15, 9, 17, 3, 27, 7, 13, 23, 32,
                       25, 19, 8, 30, 29, 4, 22, 14, 1, 21, 11, 26, 28, 6, 18, 12};

    inverse_permutation dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .Inv_Perm_Input       (in_data),
        .Inv_Perm_In_Valid    (in_valid),
        .Inv_Perm_In_Ready    (in_ready),
        .Inv_Perm_Output      (out_data),
        .Inv_Perm_Out_Valid   (out_valid),
        .Inv_Perm_Out_Ready   (out_ready),
        .Inv_Perm_Count       (count),
        .Inv_Perm_Check_Error (check_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 32'h0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        exp_count = 0;
    endtask

    function automatic logic [31:0] walk_exp(input int j);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 1; i <= 32; i++)
            if (src[i] == j) r[i-1] = 1'b1;
        return r;
    endfunction

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_count = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 32'h0;
        #12;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_in_ready",  {31'h0, in_ready},  32'h1);
        chk("rst_count",     {24'h0, count},     32'h0);
        chk("rst_output",    out_data,           32'h0);
        chk("rst_check_err", {31'h0, check_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single bits and fixed patterns, consumer always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0001;
        step();
        chk("bit1_valid", {31'h0, out_valid}, 32'h1);
        chk("bit1_out",   out_data, 32'h0000_0080);
        in_data = 32'h8000_0000;
        step(); exp_count++;
        chk("bit32_out",  out_data, 32'h0001_0000);
        in_data = 32'hFFFF_FFFF;
        step(); exp_count++;
        chk("ones_out",   out_data, 32'hFFFF_FFFF);
        in_data = 32'h0000_0000;
        step(); exp_count++;
        chk("zeros_out",  out_data, 32'h0000_0000);
        in_data = 32'h0000_0003;
        step(); exp_count++;
        chk("bits12_out", out_data, 32'h1000_0080);
        in_valid = 1'b0;
        step(); exp_count++;
        chk("drain_valid", {31'h0, out_valid}, 32'h0);
        chk("drain_count", {24'h0, count}, exp_count);

        // Walking one from a fresh reset so the pop count is exactly 32
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            in_data = 32'h1 << (j - 1);
            step();
            chk($sformatf("walk_%0d", j), out_data, walk_exp(j));
        end
        in_valid = 1'b0;
        step();
        chk("walk_count", {24'h0, count}, 32'd32);
        chk("walk_empty", {31'h0, out_valid}, 32'h0);

        // Backpressure: A and B accepted, C held off until space frees
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0001;
        step();
        chk("bp_ready_after_a", {31'h0, in_ready}, 32'h1);
        in_data = 32'h8000_0000;
        step();
        chk("bp_ready_after_b", {31'h0, in_ready}, 32'h0);
        in_data = 32'h8000_0001;
        step();
        step();
        chk("bp_stall_head",  out_data, 32'h0000_0080);
        chk("bp_stall_ready", {31'h0, in_ready}, 32'h0);
        chk("bp_stall_count", {24'h0, count}, 32'h0);
        out_ready = 1'b1;
        step();
        chk("bp_out_b", out_data, 32'h0001_0000);
        step();
        chk("bp_out_c", out_data, 32'h0001_0080);
        in_valid = 1'b0;
        step();
        chk("bp_empty", {31'h0, out_valid}, 32'h0);
        chk("bp_count", {24'h0, count}, 32'd3);

        // Concurrent push and pop in ONE for 10 cycles
        do_reset();
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        step();
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            in_data = 32'h1 << (k - 1);
            step();
            chk($sformatf("pp_out_%0d", k), out_data, walk_exp(k));
            chk($sformatf("pp_ready_%0d", k), {30'h0, in_ready, out_valid}, 32'h3);
        end
        chk("pp_count", {24'h0, count}, 32'd10);
        in_valid = 1'b0;
        step();
        chk("pp_empty", {31'h0, out_valid}, 32'h0);
        chk("pp_count_end", {24'h0, count}, 32'd11);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1234_5678;
        step();
        in_data   = 32'h9ABC_DEF0;
        step();
        chk("full_ready", {31'h0, in_ready}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("arst_in_ready",  {31'h0, in_ready},  32'h1);
        chk("arst_count",     {24'h0, count},     32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h0000_0003;
        step();
        chk("post_rst_out",   out_data, 32'h1000_0080);
        chk("post_rst_valid", {31'h0, out_valid}, 32'h1);
        in_valid = 1'b0;
        step();
        chk("post_rst_count", {24'h0, count}, 32'h1);
        chk("final_check_err", {31'h0, check_err}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
